// File: rtl/wdt_ctrl.sv
// Watchdog timer controller: register-mapped enable/kick/compare with a
// registered timeout level that stays high until a kick or disable.
module wdt_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_req,
  input  logic        reg_we,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ack,
  output logic        timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COUNT   = 2'd1;
  localparam logic [1:0] S_EXPIRED = 2'd2;

  localparam logic [7:0] A_WDEN   = 8'h00;
  localparam logic [7:0] A_WDLIVE = 8'h04;
  localparam logic [7:0] A_WTOCNT = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h0C;
  localparam logic [7:0] A_COUNT  = 8'h10;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [CNT_W-1:0] wtocnt, wtocnt_nxt;
  logic [31:0]      rdata_nxt;
  logic             access, wr, enabled, kick, wden_wr;

  // A request is taken only while no ack is showing, so one access per handshake.
  assign access  = reg_req && !reg_ack;
  assign wr      = access && reg_we;
  assign enabled = (state != S_IDLE);
  assign kick    = wr && (reg_addr == A_WDLIVE) && reg_wdata[0] && enabled;
  assign wden_wr = wr && (reg_addr == A_WDEN);

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    wtocnt_nxt  = wtocnt;

    // Normal progress compares against the pre-edge compare value.
    case (state)
      S_IDLE:    ;
      S_COUNT: begin
        if (counter >= wtocnt)      state_nxt   = S_EXPIRED;
        else if (counter != '1)     counter_nxt = counter + CNT_W'(1);
      end
      S_EXPIRED: ;
      default:   state_nxt = S_IDLE;
    endcase

    // Kick overrides a coincident expiry; disable overrides everything.
    if (kick) begin
      state_nxt   = S_COUNT;
      counter_nxt = '0;
    end
    if (wden_wr) begin
      if (!reg_wdata[0]) begin
        state_nxt   = S_IDLE;
        counter_nxt = '0;
      end else if (state == S_IDLE) begin
        state_nxt   = S_COUNT;
        counter_nxt = '0;
      end
    end
    if (wr && (reg_addr == A_WTOCNT)) wtocnt_nxt = reg_wdata[CNT_W-1:0];
  end

  always_comb begin
    rdata_nxt = '0;
    case (reg_addr)
      A_WDEN:   rdata_nxt[0]         = enabled;
      A_WTOCNT: rdata_nxt[CNT_W-1:0] = wtocnt;
      A_STATUS: rdata_nxt[1:0]       = {timeout, enabled};
      A_COUNT:  rdata_nxt[CNT_W-1:0] = counter;
      default:  ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      counter   <= '0;
      wtocnt    <= '0;
      timeout   <= 1'b0;
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      wtocnt  <= wtocnt_nxt;
      timeout <= (state_nxt == S_EXPIRED);
      reg_ack <= access;
      if (access) reg_rdata <= reg_we ? 32'h0 : rdata_nxt;
    end
  end

endmodule
